alu_cmd_seq: RTL
================

Name: alu_cmd_seq

Overview:
Sequential initiator for the combinational 4-bit ALU (alu_top). It accepts tagged ALU commands over a valid/ready stream and buffers them in a small FIFO. It drives each command onto the ALU operand and opcode ports, holds them for a fixed settle time, then captures result and carry. Each captured result is returned as a tagged response stream with backpressure. This replaces bench-style timed stimulus with a handshaked hardware front end.

Parameters:
DEPTH, 4, command FIFO depth; power of 2, minimum 2.
TAG_W, 4, width of the command/response tag.
SETTLE_CYC, 1, cycles the operands are held on the ALU before capture; minimum 1.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  FIFO can accept a command; equals !full.
cmd_a  in  4  operand A.
cmd_b  in  4  operand B.
cmd_op  in  3  ALU opcode.
cmd_tag  in  TAG_W  tag echoed on the response.
alu_a  out  4  to alu_top.A.
alu_b  out  4  to alu_top.B.
alu_opcode  out  3  to alu_top.opcode.
alu_result  in  8  from alu_top.result.
alu_carry  in  1  from alu_top.carry.
rsp_valid  out  1  response present.
rsp_ready  in  1  consumer accepts the response.
rsp_result  out  8  captured alu_result.
rsp_carry  out  1  captured alu_carry.
rsp_tag  out  TAG_W  tag of the command.
rsp_dz  out  1  divide-by-zero: opcode was DIV and B was 0.
busy  out  1  FSM not in IDLE, or FIFO not empty.
ops_done  out  8  count of completed response handshakes; wraps 255 -> 0.

Behaviour:
- Reset, asynchronous, all outputs: every output is 0 and the FIFO is empty. The exception is cmd_ready, which is 1 because the FIFO is not full. Any in-flight command and any pending response are discarded. Deassertion takes effect from the next rising edge.
- FIFO push: occurs on cmd_valid & cmd_ready. With DEPTH entries, cmd_ready is 0 when full. cmd_ready is registered from occupancy; a same-cycle pop does not free space for a same-cycle push (no bypass).
- FIFO pointers: read and write pointers wrap modulo DEPTH.
- FSM states: IDLE, DRIVE, RESP.
- IDLE: if the FIFO is not empty, pop the head. Load alu_a, alu_b and alu_opcode plus the tag and dz into holding registers. Set settle_cnt = SETTLE_CYC-1 and go to DRIVE. Otherwise stay in IDLE.
- DRIVE: if settle_cnt == 0, capture alu_result and alu_carry into rsp_result and rsp_carry, load rsp_tag and rsp_dz, set rsp_valid=1 and go to RESP. Otherwise decrement settle_cnt.
- RESP: rsp_valid is held at 1, and all rsp_* fields stay stable until rsp_valid & rsp_ready.
- On the RESP handshake: increment ops_done and clear rsp_valid. If the FIFO is not empty, pop and load the next command and go directly to DRIVE. Otherwise go to IDLE.
- alu_a, alu_b and alu_opcode keep their last-issued values in IDLE; they are never cleared except by reset.
- Latency: with the FIFO empty and the FSM in IDLE, rsp_valid rises SETTLE_CYC+1 cycles after the accepting edge of cmd_valid & cmd_ready.
- Back-to-back throughput: one response per SETTLE_CYC+1 cycles when rsp_ready is held at 1.
- rsp_dz is computed at pop time as (op == OP_DIV) && (b == 0). The result from the ALU is still captured unchanged; the sequencer does no substitution.
- Opcodes are not checked; all 8 encodings are passed through.
- If rsp_ready is held at 0, the FIFO keeps filling up to DEPTH, then cmd_ready drops. No command is lost.

Decomposition:
- Package alu_pkg: opcode constants OP_ADD=000, OP_SUB=001, OP_MUL=010, OP_DIV=011, OP_OR=100, OP_AND=101, OP_ROT=110, OP_CMP=111; FSM state enum; command struct {a, b, op, tag}.
- Sub-module alu_cmd_fifo: a parameterised synchronous FIFO with full and empty flags, using the same clk and rst_n.
- Top level: alu_cmd_seq contains the FSM, the settle counter and the response registers, and is instantiated alongside alu_top.

Test Plan:
The bench uses a behavioural ALU model in place of alu_top: ADD returns {3'b0, A+B} with carry = (A+B)[4]; the other opcodes return fixed known values.
- Single ADD: A=5, B=12, op=000, tag=1, SETTLE_CYC=1 -> rsp_valid exactly 2 cycles after accept; rsp_result=8'h11, rsp_carry=1, rsp_tag=1, rsp_dz=0, ops_done=1.
- Divide by zero: A=7, B=0, op=011 -> rsp_dz=1. Then A=7, B=2, op=011 -> rsp_dz=0. Both tags are returned in order.
- Backpressure and full: hold rsp_ready=0 and push 6 commands -> 1 command in RESP, 4 in the FIFO, cmd_ready=0 after the 5th accept, and the 6th is held. Release rsp_ready=1 -> 6 responses in push order, with tags 0..5 unchanged.
- Back-to-back: 8 commands with rsp_ready=1, SETTLE_CYC=2 -> one response every 3 cycles; the overflow case ADD 15+15 returns 8'h1E with carry=1.
- Reset mid-operation: assert rst_n=0 while in DRIVE with 3 commands queued -> immediately rsp_valid=0, busy=0, ops_done=0, cmd_ready=1. After release, no stale response appears.
- ops_done wrap: 256 completed handshakes -> ops_done returns to 0.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU command sequencer.
//   - opcode encodings understood by alu_top
//   - sequencer FSM state encodings
//   - packed command payload (operands + opcode) carried through the FIFO
//   - divide-by-zero helper evaluated when a command is popped
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_ROT = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  // The tag width is a module parameter, so the tag travels next to this
  // struct rather than inside it.
  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
  } alu_cmd_t;

  function automatic logic is_div_zero(input alu_cmd_t cmd);
    return (cmd.op == OP_DIV) && (cmd.b == 4'd0);
  endfunction

endpackage

// File: rtl/alu_cmd_seq_if.sv
// alu_cmd_seq_if: command and response streams of the ALU sequencer.
//   cmd_valid/cmd_ready  command handshake; cmd_a, cmd_b, cmd_op, cmd_tag payload
//   rsp_valid/rsp_ready  response handshake; rsp_result, rsp_carry, rsp_tag, rsp_dz payload
// master: the side issuing commands and consuming responses.
// slave:  the sequencer.
interface alu_cmd_seq_if #(
  parameter int TAG_W = 4
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_a;
  logic [3:0]       cmd_b;
  logic [2:0]       cmd_op;
  logic [TAG_W-1:0] cmd_tag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [7:0]       rsp_result;
  logic             rsp_carry;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_dz;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_tag, rsp_dz
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_tag, rsp_dz
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous FIFO for queued ALU commands.
//   clk, rst_n   clock, asynchronous active-low reset (empties the FIFO)
//   push/wr_data write request and data; ignored while full
//   pop/rd_data  read request; rd_data always shows the head entry
//   full/empty   occupancy flags derived from the registered count only
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = DEPTH;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // Flags come from the registered count, so a pop in the same cycle never
  // makes room for a push in that cycle.
  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/alu_cmd_seq.sv
// alu_cmd_seq: handshaked front end for the combinational alu_top.
//   clk, rst_n              clock, asynchronous active-low reset
//   bus (slave)             command stream in, tagged response stream out
//   alu_a/alu_b/alu_opcode  operands and opcode driven to alu_top
//   alu_result/alu_carry    result returned by alu_top
//   busy                    a command is in flight or queued
//   ops_done                completed response handshakes, wraps at 256
// Commands are queued, held on the ALU for SETTLE_CYC cycles, then the
// result is captured and offered as a response until it is accepted.
module alu_cmd_seq #(
  parameter int DEPTH      = 4,
  parameter int TAG_W      = 4,
  parameter int SETTLE_CYC = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_cmd_seq_if.slave   bus,
  output logic [3:0]     alu_a,
  output logic [3:0]     alu_b,
  output logic [2:0]     alu_opcode,
  input  logic [7:0]     alu_result,
  input  logic           alu_carry,
  output logic           busy,
  output logic [7:0]     ops_done
);

  import alu_pkg::*;

  localparam int FIFO_W = TAG_W + $bits(alu_cmd_t);
  localparam int CNT_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = 1;

  logic [1:0]        state;
  logic [CNT_W-1:0]  settle_cnt;
  logic [TAG_W-1:0]  tag_hold;
  logic              dz_hold;

  logic              rsp_valid_q;
  logic [7:0]        rsp_result_q;
  logic              rsp_carry_q;
  logic [TAG_W-1:0]  rsp_tag_q;
  logic              rsp_dz_q;

  logic [FIFO_W-1:0] fifo_wr;
  logic [FIFO_W-1:0] fifo_rd;
  alu_cmd_t          wr_cmd;
  alu_cmd_t          head_cmd;
  logic [TAG_W-1:0]  head_tag;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              rsp_fire;

  assign wr_cmd.a  = bus.cmd_a;
  assign wr_cmd.b  = bus.cmd_b;
  assign wr_cmd.op = bus.cmd_op;
  assign fifo_wr   = {bus.cmd_tag, wr_cmd};
  assign {head_tag, head_cmd} = fifo_rd;

  assign bus.cmd_ready  = !full;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_carry  = rsp_carry_q;
  assign bus.rsp_tag    = rsp_tag_q;
  assign bus.rsp_dz     = rsp_dz_q;

  assign push     = bus.cmd_valid && !full;
  assign rsp_fire = rsp_valid_q && bus.rsp_ready;

  // A command leaves the FIFO either from IDLE or straight out of RESP on the
  // accepting handshake, which is what gives back-to-back throughput.
  assign pop  = !empty && ((state == ST_IDLE) || ((state == ST_RESP) && rsp_fire));
  assign busy = (state != ST_IDLE) || !empty;

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (fifo_wr),
    .pop     (pop),
    .rd_data (fifo_rd),
    .full    (full),
    .empty   (empty)
  );

  // The case handles settling and response bookkeeping; the pop branch after
  // it loads the next command and overrides the IDLE fallback from RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      settle_cnt   <= '0;
      tag_hold     <= '0;
      dz_hold      <= 1'b0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_opcode   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_tag_q    <= '0;
      rsp_dz_q     <= 1'b0;
      ops_done     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state <= ST_IDLE;
        end
        ST_DRIVE: begin
          if (settle_cnt == '0) begin
            rsp_result_q <= alu_result;
            rsp_carry_q  <= alu_carry;
            rsp_tag_q    <= tag_hold;
            rsp_dz_q     <= dz_hold;
            rsp_valid_q  <= 1'b1;
            state        <= ST_RESP;
          end else begin
            settle_cnt <= settle_cnt - CNT_ONE;
          end
        end
        ST_RESP: begin
          if (rsp_fire) begin
            rsp_valid_q <= 1'b0;
            ops_done    <= ops_done + 8'd1;
            state       <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase

      if (pop) begin
        alu_a      <= head_cmd.a;
        alu_b      <= head_cmd.b;
        alu_opcode <= head_cmd.op;
        tag_hold   <= head_tag;
        dz_hold    <= is_div_zero(head_cmd);
        settle_cnt <= SETTLE_LOAD;
        state      <= ST_DRIVE;
      end
    end
  end

endmodule
